// File: rtl/fft_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fft_ctrl_pkg
// Shared definitions for the FFT frame sequencer: sequencer state encoding
// and the default frame / spectrum geometry.
// No ports (package).
// ---------------------------------------------------------------------------
package fft_ctrl_pkg;

    localparam int DEFAULT_WORD_SIZE  = 16;
    localparam int DEFAULT_NUM_POINTS = 4096;
    localparam int DEFAULT_POINT_BITS = 12;
    localparam int DEFAULT_NUM_BINS   = 1024;
    localparam int DEFAULT_BIN_BITS   = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

endpackage

// File: rtl/fft_sink_holder.sv
// ---------------------------------------------------------------------------
// fft_sink_holder
// One-entry holding register between the free-running sample strobe and the
// FFT core sink interface. A strobe loads the entry (1-cycle latency); a
// transfer (valid && ready) empties it unless a new sample loads in the same
// cycle. A strobe that finds the entry full and not draining is dropped and
// sets the sticky overrun flag.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   accept        strobes are only taken while high
//   sample_valid  input sample strobe
//   sample_data   input sample
//   ready         core sink ready
//   valid         entry full / sample offered to the core
//   data          held sample
//   overrun       sticky, a sample was dropped
// ---------------------------------------------------------------------------
module fft_sink_holder
    import fft_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 accept,
    input  logic                 sample_valid,
    input  logic [WORD_SIZE-1:0] sample_data,
    input  logic                 ready,
    output logic                 valid,
    output logic [WORD_SIZE-1:0] data,
    output logic                 overrun
);

    logic load_req;
    logic drop;
    logic load;

    always_comb begin
        load_req = sample_valid && accept;
        // Full and stalled: nowhere to put the new sample.
        drop     = load_req && valid && !ready;
        load     = load_req && !drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            data    <= '0;
            overrun <= 1'b0;
        end else begin
            // A load in the same cycle as a transfer keeps the entry full.
            if (load) begin
                valid <= 1'b1;
                data  <= sample_data;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// ---------------------------------------------------------------------------
// fft_frame_sequencer
// Packs the sample strobe into NUM_POINTS-sample frames for a streaming FFT
// core (sop/eop framing, sink backpressure) and writes the first NUM_BINS
// output bins of each result frame to the spectrum RAM.
//
// Ports:
//   inClock, reset        clock, synchronous active-high reset
//   enable                run frames (looked at only on frame boundaries)
//   sampleValid/Data      input sample strobe and data
//   sinkValid/Sop/Eop/Data, sinkReady   FFT core sink interface
//   sourceValid/Sop/Eop   FFT core source framing
//   binAddr, binWrite     spectrum RAM write port
//   frameDone             one-cycle pulse per completed output frame
//   busy                  sequencer not idle
//   overrun               sticky, a sample was lost while feeding
// ---------------------------------------------------------------------------
module fft_frame_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int WORD_SIZE  = DEFAULT_WORD_SIZE,
    parameter int NUM_POINTS = DEFAULT_NUM_POINTS,
    parameter int POINT_BITS = DEFAULT_POINT_BITS,
    parameter int NUM_BINS   = DEFAULT_NUM_BINS,
    parameter int BIN_BITS   = DEFAULT_BIN_BITS
) (
    input  logic                 inClock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sampleValid,
    input  logic [WORD_SIZE-1:0] sampleData,
    output logic                 sinkValid,
    output logic                 sinkSop,
    output logic                 sinkEop,
    output logic [WORD_SIZE-1:0] sinkData,
    input  logic                 sinkReady,
    input  logic                 sourceValid,
    input  logic                 sourceSop,
    input  logic                 sourceEop,
    output logic [BIN_BITS-1:0]  binAddr,
    output logic                 binWrite,
    output logic                 frameDone,
    output logic                 busy,
    output logic                 overrun
);

    localparam logic [POINT_BITS-1:0] LAST_IDX  = POINT_BITS'(NUM_POINTS - 1);
    localparam logic [BIN_BITS:0]     BIN_LIMIT = (BIN_BITS + 1)'(NUM_BINS);

    seq_state_t             state;
    seq_state_t             state_next;
    logic [POINT_BITS-1:0]  in_idx;
    logic [BIN_BITS:0]      out_idx;
    logic                   armed;

    logic                   xfer;
    logic                   eop_xfer;
    logic                   accept;
    logic                   beat;
    logic                   eff_armed;
    logic [BIN_BITS:0]      eff_idx;
    logic                   wr_next;
    logic                   done_next;

    // Input side: holder, framing and frame index
    always_comb begin
        xfer     = sinkValid && sinkReady;
        eop_xfer = xfer && (in_idx == LAST_IDX);
        // A strobe coinciding with the eop transfer belongs to the drain
        // window and is discarded, so the holder is empty throughout DRAIN.
        accept   = (state == FEED) && !eop_xfer;
    end

    fft_sink_holder #(
        .WORD_SIZE (WORD_SIZE)
    ) u_holder (
        .clk          (inClock),
        .rst          (reset),
        .accept       (accept),
        .sample_valid (sampleValid),
        .sample_data  (sampleData),
        .ready        (sinkReady),
        .valid        (sinkValid),
        .data         (sinkData),
        .overrun      (overrun)
    );

    assign sinkSop = sinkValid && (in_idx == '0);
    assign sinkEop = sinkValid && (in_idx == LAST_IDX);
    assign busy    = (state != IDLE);

    // NUM_POINTS is a power of two, so the natural wrap returns to 0 after eop.
    always_ff @(posedge inClock) begin
        if (reset) begin
            in_idx <= '0;
        end else if (state == IDLE) begin
            in_idx <= '0;
        end else if (xfer) begin
            in_idx <= in_idx + 1'b1;
        end
    end

    // Sequencer FSM
    always_ff @(posedge inClock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable)    state_next = FEED;
            FEED:    if (eop_xfer)  state_next = DRAIN;
            DRAIN:   if (frameDone) state_next = enable ? FEED : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output side: bin writer
    always_comb begin
        beat      = sourceValid && (state != IDLE);
        // A sop beat both arms and restarts the count in the same cycle.
        eff_armed = sourceSop || armed;
        eff_idx   = sourceSop ? '0 : out_idx;
        wr_next   = beat && eff_armed && (eff_idx < BIN_LIMIT);
        done_next = beat && eff_armed && sourceEop;
    end

    always_ff @(posedge inClock) begin
        if (reset) begin
            out_idx   <= '0;
            armed     <= 1'b0;
            binWrite  <= 1'b0;
            binAddr   <= '0;
            frameDone <= 1'b0;
        end else begin
            binWrite  <= wr_next;
            frameDone <= done_next;
            if (wr_next) begin
                binAddr <= eff_idx[BIN_BITS-1:0];
            end
            // Counting stops at NUM_BINS so the index can never wrap back
            // into the written range on long frames.
            if (beat && eff_armed) begin
                out_idx <= wr_next ? eff_idx + 1'b1 : eff_idx;
            end
            if (done_next) begin
                armed <= 1'b0;
            end else if (beat && sourceSop) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
module tb_fft_frame_sequencer;
    import fft_ctrl_pkg::*;

    localparam int WS  = 16;
    localparam int NP  = 8;
    localparam int PB  = 3;
    localparam int NB  = 4;
    localparam int BB  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          sampleValid;
    logic [WS-1:0] sampleData;
    logic          sinkValid, sinkSop, sinkEop;
    logic [WS-1:0] sinkData;
    logic          sinkReady;
    logic          sourceValid, sourceSop, sourceEop;
    logic [BB-1:0] binAddr;
    logic          binWrite, frameDone, busy, overrun;

    typedef struct packed {
        logic [WS-1:0] d;
        logic          sop;
        logic          eop;
    } exp_t;

    exp_t          sb[$];
    logic [BB-1:0] bin_q[$];
    int            total = 0;
    int            bad   = 0;
    int            fd_cnt = 0;
    int            wr_cnt = 0;
    int            pos = 0;

    fft_frame_sequencer #(
        .WORD_SIZE(WS), .NUM_POINTS(NP), .POINT_BITS(PB), .NUM_BINS(NB), .BIN_BITS(BB)
    ) dut (
        .inClock(clk), .reset(rst), .enable(enable),
        .sampleValid(sampleValid), .sampleData(sampleData),
        .sinkValid(sinkValid), .sinkSop(sinkSop), .sinkEop(sinkEop),
        .sinkData(sinkData), .sinkReady(sinkReady),
        .sourceValid(sourceValid), .sourceSop(sourceSop), .sourceEop(sourceEop),
        .binAddr(binAddr), .binWrite(binWrite), .frameDone(frameDone),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    // Sink scoreboard: every transfer must match the oldest expected sample.
    exp_t e_mon;
    exp_t got_mon;
    always @(negedge clk) begin
        if (!rst && sinkValid && sinkReady) begin
            got_mon = '{d: sinkData, sop: sinkSop, eop: sinkEop};
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL sink_extra: got data=%0h, want no transfer", sinkData);
            end
            if (sb.size() > 0) begin
                e_mon = sb.pop_front();
                total++;
                assert (got_mon === e_mon) else begin
                    bad++;
                    $error("FAIL sink_xfer: got d=%0h sop=%0b eop=%0b, want d=%0h sop=%0b eop=%0b",
                           got_mon.d, got_mon.sop, got_mon.eop, e_mon.d, e_mon.sop, e_mon.eop);
                end
            end
        end
    end

    // Bin write scoreboard.
    logic [BB-1:0] a_mon;
    always @(negedge clk) begin
        if (frameDone) fd_cnt++;
        if (binWrite) begin
            wr_cnt++;
            total++;
            assert (bin_q.size() > 0) else begin
                bad++;
                $error("FAIL bin_extra: got write addr=%0d, want no write", binAddr);
            end
            if (bin_q.size() > 0) begin
                a_mon = bin_q.pop_front();
                total++;
                assert (binAddr === a_mon) else begin
                    bad++;
                    $error("FAIL bin_addr: got %0d, want %0d", binAddr, a_mon);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        @(negedge clk);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [WS-1:0] d);
        sampleValid = 1'b1;
        sampleData  = d;
        sb.push_back('{d: d, sop: (pos == 0), eop: (pos == NP - 1)});
        pos = (pos + 1) % NP;
        tick();
        sampleValid = 1'b0;
    endtask

    task automatic send_drop(input logic [WS-1:0] d);
        sampleValid = 1'b1;
        sampleData  = d;
        tick();
        sampleValid = 1'b0;
    endtask

    task automatic beat(input logic sop, input logic eop, input logic expect_wr,
                        input logic [BB-1:0] addr);
        sourceValid = 1'b1;
        sourceSop   = sop;
        sourceEop   = eop;
        if (expect_wr) bin_q.push_back(addr);
        tick();
        sourceValid = 1'b0;
        sourceSop   = 1'b0;
        sourceEop   = 1'b0;
    endtask

    // Full output frame of NP beats; the first NB write bins 0..NB-1.
    task automatic out_frame();
        for (int i = 0; i < NP; i++) begin
            beat(i == 0, i == NP - 1, i < NB, BB'(i));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        @(negedge clk);
        total++;
        assert ({sinkValid, sinkSop, sinkEop, sinkData, binAddr, binWrite, frameDone, busy, overrun}
                === '0) else begin
            bad++;
            $error("FAIL %s: got v=%0b sop=%0b eop=%0b d=%0h addr=%0d wr=%0b done=%0b busy=%0b ovr=%0b, want all 0",
                   tag, sinkValid, sinkSop, sinkEop, sinkData, binAddr, binWrite, frameDone, busy, overrun);
        end
    endtask

    int fd0;
    int wr0;

    initial begin
        rst = 1'b1; enable = 1'b0; sampleValid = 1'b0; sampleData = '0;
        sinkReady = 1'b0; sourceValid = 1'b0; sourceSop = 1'b0; sourceEop = 1'b0;
        tick(); tick(); tick();
        chk_all_zero("reset_state");
        chk("reset_state_idle", 32'(dut.state), 32'(IDLE));

        // Basic frame
        rst = 1'b0; enable = 1'b1; sinkReady = 1'b1;
        tick();
        chk("busy_feed", 32'(busy), 32'd1);
        for (int i = 1; i <= NP; i++) send(WS'(i));
        tick();
        chk("state_drain1", 32'(dut.state), 32'(DRAIN));
        chk("sink_empty_drain", 32'(sinkValid), 32'd0);
        chk("sb_empty1", 32'(sb.size()), 32'd0);

        // Samples in DRAIN are discarded silently
        send_drop(16'h00aa);
        tick();
        chk("drain_discard_valid", 32'(sinkValid), 32'd0);
        chk("drain_no_overrun", 32'(overrun), 32'd0);

        // Stray beats without a sop
        fd0 = fd_cnt; wr0 = wr_cnt;
        beat(1'b0, 1'b0, 1'b0, '0);
        beat(1'b0, 1'b0, 1'b0, '0);
        beat(1'b0, 1'b1, 1'b0, '0);
        tick();
        chk("stray_no_done", 32'(fd_cnt - fd0), 32'd0);
        chk("stray_no_write", 32'(wr_cnt - wr0), 32'd0);
        chk("stray_still_drain", 32'(dut.state), 32'(DRAIN));

        // Output mapping
        fd0 = fd_cnt; wr0 = wr_cnt;
        out_frame();
        chk("frame_done_pulse", 32'(frameDone), 32'd1);
        tick();
        chk("frame_done_low", 32'(frameDone), 32'd0);
        chk("state_feed_after_done", 32'(dut.state), 32'(FEED));
        tick(); tick();
        chk("done_single", 32'(fd_cnt - fd0), 32'd1);
        chk("writes_four", 32'(wr_cnt - wr0), 32'd4);
        chk("bin_q_empty", 32'(bin_q.size()), 32'd0);

        // Backpressure without loss
        for (int g = 0; g < 2; g++) begin
            sinkReady = 1'b0;
            send(WS'(11 + g));
            tick(); tick();
            sinkReady = 1'b1;
            tick();
        end
        chk("bp_no_overrun", 32'(overrun), 32'd0);

        // Two strobes while stalled: second one lost
        sinkReady = 1'b0;
        send(16'd13);
        send_drop(16'd14);
        chk("overrun_set", 32'(overrun), 32'd1);
        chk("held_kept", 32'(sinkData), 32'd13);
        sinkReady = 1'b1;
        tick();
        for (int i = 16; i <= 20; i++) send(WS'(i));
        tick();
        chk("overrun_sticky", 32'(overrun), 32'd1);
        chk("state_drain2", 32'(dut.state), 32'(DRAIN));
        out_frame();
        tick();
        chk("state_feed2", 32'(dut.state), 32'(FEED));

        // Disable mid-frame: frame still completes
        send(16'd21); send(16'd22); send(16'd23);
        enable = 1'b0;
        for (int i = 24; i <= 28; i++) send(WS'(i));
        tick();
        chk("state_drain3", 32'(dut.state), 32'(DRAIN));
        chk("sb_empty3", 32'(sb.size()), 32'd0);
        out_frame();
        tick();
        chk("state_idle_after_disable", 32'(dut.state), 32'(IDLE));
        chk("busy_low", 32'(busy), 32'd0);
        send_drop(16'h0077);
        tick();
        chk("idle_ignores_samples", 32'(sinkValid), 32'd0);

        // Reset mid-frame
        enable = 1'b1;
        tick();
        for (int i = 31; i <= 34; i++) send(WS'(i));
        rst = 1'b1;
        sampleValid = 1'b1;
        sampleData  = 16'd35;
        tick();
        sampleValid = 1'b0;
        sb.delete();
        pos = 0;
        chk_all_zero("reset_midframe");
        rst = 1'b0;
        tick();
        send(16'd41);
        tick(); tick();
        chk("sb_empty_after_reenable", 32'(sb.size()), 32'd0);
        chk("busy_after_reenable", 32'(busy), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Sequences the streaming FFT core: packs a free-running sample strobe into NUM_POINTS-sample frames with sop/eop framing, and honours the core's sink ready.
- Tracks the output frame and drives the spectrum RAM write port for the first NUM_BINS bins.
- Sits between the audio sample source and the FFT core / magnitude / display RAM path.
- Owns frame start/stop, gap handling and overrun reporting.

Parameters:
- WORD_SIZE, 16, sample width.
- NUM_POINTS, 4096, FFT frame length (power of 2).
- POINT_BITS, 12, log2(NUM_POINTS).
- NUM_BINS, 1024, bins written to the display RAM per frame (≤ NUM_POINTS).
- BIN_BITS, 10, log2(NUM_BINS).

Ports:
- inClock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run frames; sampled only at frame boundaries.
- sampleValid  in  1  one-cycle strobe, new input sample.
- sampleData  in  WORD_SIZE  input sample.
- sinkValid  out  1  sample valid to FFT core.
- sinkSop  out  1  first sample of frame.
- sinkEop  out  1  last sample of frame.
- sinkData  out  WORD_SIZE  sample to FFT core.
- sinkReady  in  1  FFT core accepts the sample.
- sourceValid  in  1  FFT output bin valid.
- sourceSop  in  1  first output bin.
- sourceEop  in  1  last output bin.
- binAddr  out  BIN_BITS  spectrum RAM write address.
- binWrite  out  1  spectrum RAM write enable.
- frameDone  out  1  one-cycle pulse, output frame complete.
- busy  out  1  high in any state except IDLE.
- overrun  out  1  sticky; a sample was lost while feeding.

Behaviour:
- Reset (synchronous, inClock edge with reset=1): state=IDLE. All outputs 0: sinkValid, sinkSop, sinkEop, sinkData, binAddr, binWrite, frameDone, busy, overrun. Counters and the holding register are cleared. Reset mid-frame abandons the frame; the bench must also reset the FFT core.
- States:
  - IDLE: enable=1 → FEED, with inIdx=0.
  - FEED: samples are forwarded to the core. The eop transfer → DRAIN.
  - DRAIN: input samples are discarded, with no overrun. Waits for the output frame. frameDone → FEED if enable=1, else IDLE.
- Holding register: 1 entry.
  - sampleValid loads sampleData into sinkData and sets sinkValid on the next edge (1-cycle latency).
  - A transfer is sinkValid && sinkReady. It clears sinkValid unless a new sample loads in the same cycle; load wins, and the register stays full.
  - sampleValid while full and sinkReady=0 → new sample dropped, overrun set. overrun is cleared only by reset.
- Framing:
  - sinkSop = sinkValid && inIdx==0.
  - sinkEop = sinkValid && inIdx==NUM_POINTS-1.
  - Both are combinational from the registered index.
  - inIdx increments only on a transfer, and wraps to 0 after eop.
  - enable deassertion mid-frame never truncates; the frame completes.
- Output side:
  - Any cycle with sourceValid && sourceSop sets outIdx=0 and marks the frame armed. A new sop while armed restarts the count.
  - sourceValid before the first sop is ignored.
  - Each armed sourceValid with outIdx<NUM_BINS → binWrite=1, binAddr=outIdx[BIN_BITS-1:0] on the next edge (1-cycle registered latency). outIdx then increments.
  - outIdx≥NUM_BINS → no write.
  - sourceValid && sourceEop while armed → frameDone pulses 1 cycle later, and armed clears.
- Output tracking is active in FEED and DRAIN. The core may stream frame k while frame k+1 is being fed, but state leaves DRAIN only on frameDone.
- busy = (state != IDLE).

Decomposition:
- Package fft_ctrl_pkg: state enum (IDLE, FEED, DRAIN), width constants and the default NUM_POINTS/NUM_BINS.
- One sub-module: fft_sink_holder (1-entry holding register with overrun detection).
- Framing counters, FSM and bin writer stay in the top level.

Test Plan (NUM_POINTS=8, POINT_BITS=3, NUM_BINS=4, BIN_BITS=2):
- Basic frame: reset, then enable=1, sinkReady=1, samples 1..8 on consecutive cycles → sinkValid one cycle after each strobe; sinkSop with data 1; sinkEop with data 8; state DRAIN.
- Backpressure: sinkReady=0 for 3 cycles with a sample every 4 cycles → no loss, overrun=0. Two strobes while stalled and full → second dropped, overrun=1 and stays 1.
- Output mapping: drive 8 source beats, sop on beat 0 and eop on beat 7 → binWrite on 4 cycles, binAddr 0,1,2,3. Then frameDone as a single pulse 1 cycle after the eop beat; state FEED.
- Stray output: sourceValid beats without a prior sop → no binWrite, no frameDone.
- Disable mid-frame: enable=0 after sample 3 → frame still completes through sample 8 with eop; after frameDone, state IDLE and busy=0.
- Reset mid-frame: reset at sample 5 → all outputs 0 next cycle. Re-enable → next sop carries the first new sample.
